// File: rtl/csidh_fp_correct_pkg.sv
// Shared constants for the CSIDH-512 Fp final-reduction engine: limb geometry,
// the prime p split into 64-bit limbs (LS limb first), and the FSM state encoding.
package csidh_pkg;

   localparam int XLEN   = 64;
   localparam int NLIMBS = 8;
   localparam int IDX_W  = $clog2(NLIMBS);

   localparam logic [XLEN-1:0] CSIDH_P_LIMB [0:NLIMBS-1] = '{
      64'h1b81b90533c6c87b, 64'hc2721bf457aca835,
      64'h516730cc1f0b4f25, 64'ha7aac6c567f35507,
      64'h5afbfcc69322c9cd, 64'hb42d083aedc88c42,
      64'hfc8ab0d15e3e4c4a, 64'h65b48e8f740f89bf
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      ADD  = 2'd2
   } state_t;

endpackage

// File: rtl/csidh_limb_adc.sv
// One-limb adder/subtractor with carry (or borrow) in and out.
// SUB=1 computes a - b - cin; cout is then the borrow-out.
module csidh_limb_adc
   import csidh_pkg::*;
#(
   parameter bit SUB = 1'b0
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            cin,
   output logic [XLEN-1:0] s,
   output logic            cout
);

   logic [XLEN:0] wide;

   // A 65-bit result holds the carry, or (for subtraction) the sign bit as borrow.
   always_comb begin
      if (SUB) wide = {1'b0, a} - {1'b0, b} - {{XLEN{1'b0}}, cin};
      else     wide = {1'b0, a} + {1'b0, b} + {{XLEN{1'b0}}, cin};
   end

   assign s    = wide[XLEN-1:0];
   assign cout = wide[XLEN];

endmodule

// File: rtl/csidh_fp_correct.sv
// Streaming final reduction x mod p for x < 2p: pass 1 buffers d = x - p limb by
// limb, pass 2 emits d + (p & mask) where mask is set iff pass 1 borrowed.
module csidh_fp_correct
   import csidh_pkg::*;
(
   input  logic            g_clk,
   input  logic            g_rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic            out_last,
   output logic            busy
);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             borrow;
   logic             carry;
   logic [XLEN-1:0]  mask;
   logic [XLEN-1:0]  limb_buf [0:NLIMBS-1];

   logic [XLEN-1:0]  sub_d;
   logic             sub_b;
   logic             add_c;
   logic             in_fire;
   logic             out_fire;
   logic             idx_end;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign idx_end  = (idx == IDX_W'(NLIMBS - 1));

   csidh_limb_adc #(.SUB(1'b1)) u_sub (
      .a    (in_data),
      .b    (CSIDH_P_LIMB[idx]),
      .cin  (borrow),
      .s    (sub_d),
      .cout (sub_b)
   );

   // Output path reads only registers, so nothing on in_* reaches out_*.
   csidh_limb_adc #(.SUB(1'b0)) u_add (
      .a    (limb_buf[idx]),
      .b    (CSIDH_P_LIMB[idx] & mask),
      .cin  (carry),
      .s    (out_data),
      .cout (add_c)
   );

   // NOTE: the limb buffer has no reset; every entry is rewritten in pass 1 before it is read.
   always_ff @(posedge g_clk) begin
      if (in_fire) limb_buf[idx] <= sub_d;
   end

   // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge g_clk) begin
      if (g_rst) begin
         state     <= IDLE;
         idx       <= '0;
         borrow    <= 1'b0;
         carry     <= 1'b0;
         mask      <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE, SUB: begin
               if (in_fire) begin
                  busy <= 1'b1;
                  if (idx_end) begin
                     mask      <= {XLEN{sub_b}};
                     idx       <= '0;
                     borrow    <= 1'b0;
                     state     <= ADD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_last  <= 1'b0;
                  end else begin
                     borrow <= sub_b;
                     idx    <= idx + 1'b1;
                     state  <= SUB;
                  end
               end
            end
            ADD: begin
               if (out_fire) begin
                  if (idx_end) begin
                     idx       <= '0;
                     carry     <= 1'b0;
                     state     <= IDLE;
                     in_ready  <= 1'b1;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                  end else begin
                     carry    <= add_c;
                     idx      <= idx + 1'b1;
                     out_last <= (idx == IDX_W'(NLIMBS - 2));
                  end
               end
            end
            default: begin
               state     <= IDLE;
               idx       <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
